audio_block_sched: RTL and testbench

Block-level sequencer for the I2S sample path, clocked by the audio bit clock. It turns LRCK transitions into single-cycle write strobes and addresses for ping-pong L/R receive buffers, and hands each completed block to the DSP engine with a ready/done handshake. It also steers the transmit read address to the most recently processed block, and flags overrun and underrun.

---
 rtl/audio_block_sched.sv | 197 +++++++++++++++++++
 tb/tb_audio_block_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_block_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_block_sched                                             |
// | Function : I2S block sequencer. Converts LRCK edges into L/R write       |
// |            strobes and ping-pong RX addresses, offers completed banks    |
// |            to the DSP with a ready/done handshake, steers the TX read    |
// |            bank to the latest processed block and flags over/underrun.   |
// | Options  : AUDIO_SCHED_STATS_EN adds blk_count / ovr_count outputs.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module audio_block_sched #(
  parameter int PTR_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lrck,
  input  logic                proc_done,
  input  logic                clr_flags,
`ifdef AUDIO_SCHED_STATS_EN
  output logic [15:0]         blk_count,
  output logic [7:0]          ovr_count,
`endif
  output logic                wr_en_l,
  output logic                wr_en_r,
  output logic [PTR_BITS:0]   wr_addr,
  output logic                blk_ready,
  output logic                blk_bank,
  output logic [PTR_BITS:0]   tx_addr,
  output logic                tx_mute,
  output logic                overrun,
  output logic                underrun
);

  typedef enum logic [0:0] {
    ST_UNARMED = 1'b0,
    ST_RUN     = 1'b1
  } state_t;

  localparam logic [PTR_BITS-1:0] PTR_LAST = {PTR_BITS{1'b1}};
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

  state_t              state_q, state_d;
  logic                lrck_q;
  logic                wr_en_l_q, wr_en_l_d;
  logic                wr_en_r_q, wr_en_r_d;
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                wr_bank_q, wr_bank_d;
  logic                blk_ready_q, blk_ready_d;
  logic                blk_bank_q, blk_bank_d;
  logic                done_valid_q, done_valid_d;
  logic                done_bank_q, done_bank_d;
  logic                ever_done_q, ever_done_d;
  logic                tx_bank_q, tx_bank_d;
  logic                tx_mute_q, tx_mute_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic                w_rise, w_fall, w_boundary, w_ovr_set;
`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0]         blk_count_q, blk_count_d;
  logic [7:0]          ovr_count_q, ovr_count_d;
`endif

  // LRCK history; loaded even in reset so release never shows a false edge
  always_ff @(posedge clk) begin
    lrck_q <= lrck;
  end

  // Arm FSM and strobe generation: first falling edge only aligns the frame
  always_comb begin
    state_d   = state_q;
    wr_en_l_d = 1'b0;
    wr_en_r_d = 1'b0;
    w_rise    = lrck & ~lrck_q;
    w_fall    = ~lrck & lrck_q;
    case (state_q)
      ST_UNARMED: if (w_fall) state_d = ST_RUN;
      ST_RUN: begin
        wr_en_l_d = w_rise;
        wr_en_r_d = w_fall;
      end
      default: state_d = ST_UNARMED;
    endcase
  end

  // Pointer, bank handshake and flags; a same-cycle done is applied before the boundary
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    blk_ready_d  = blk_ready_q;
    blk_bank_d   = blk_bank_q;
    done_valid_d = done_valid_q;
    done_bank_d  = done_bank_q;
    ever_done_d  = ever_done_q;
    tx_bank_d    = tx_bank_q;
    tx_mute_d    = tx_mute_q;
    overrun_d    = clr_flags ? 1'b0 : overrun_q;
    underrun_d   = clr_flags ? 1'b0 : underrun_q;
    w_ovr_set    = 1'b0;
    w_boundary   = wr_en_r_q && (wr_ptr_q == PTR_LAST);

    if (proc_done && blk_ready_q) begin
      blk_ready_d  = 1'b0;
      done_valid_d = 1'b1;
      done_bank_d  = blk_bank_q;
      ever_done_d  = 1'b1;
    end

    if (wr_en_r_q) wr_ptr_d = wr_ptr_q + PTR_ONE;

    if (w_boundary) begin
      wr_bank_d   = ~wr_bank_q;
      blk_bank_d  = wr_bank_q;
      w_ovr_set   = blk_ready_d;
      blk_ready_d = 1'b1;
      if (w_ovr_set) overrun_d = 1'b1;
      if (done_valid_d) begin
        tx_bank_d    = done_bank_d;
        done_valid_d = 1'b0;
        tx_mute_d    = 1'b0;
      end else begin
        tx_mute_d = 1'b1;
        if (ever_done_d) underrun_d = 1'b1;
      end
    end
  end

`ifdef AUDIO_SCHED_STATS_EN
  // Block counter wraps, overrun counter saturates; an event beats the clear
  always_comb begin
    blk_count_d = clr_flags ? 16'd0 : blk_count_q;
    ovr_count_d = clr_flags ? 8'd0 : ovr_count_q;
    if (w_boundary) blk_count_d = blk_count_d + 16'd1;
    if (w_ovr_set && (ovr_count_d != 8'hFF)) ovr_count_d = ovr_count_d + 8'd1;
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count_q <= 16'd0;
      ovr_count_q <= 8'd0;
    end else begin
      blk_count_q <= blk_count_d;
      ovr_count_q <= ovr_count_d;
    end
  end

  assign blk_count = blk_count_q;
  assign ovr_count = ovr_count_q;
`endif

  // State register; reset drops any pending block and disarms
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNARMED;
      wr_en_l_q    <= 1'b0;
      wr_en_r_q    <= 1'b0;
      wr_ptr_q     <= '0;
      wr_bank_q    <= 1'b0;
      blk_ready_q  <= 1'b0;
      blk_bank_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_bank_q  <= 1'b0;
      ever_done_q  <= 1'b0;
      tx_bank_q    <= 1'b0;
      tx_mute_q    <= 1'b1;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_l_q    <= wr_en_l_d;
      wr_en_r_q    <= wr_en_r_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_bank_q    <= wr_bank_d;
      blk_ready_q  <= blk_ready_d;
      blk_bank_q   <= blk_bank_d;
      done_valid_q <= done_valid_d;
      done_bank_q  <= done_bank_d;
      ever_done_q  <= ever_done_d;
      tx_bank_q    <= tx_bank_d;
      tx_mute_q    <= tx_mute_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign wr_en_l   = wr_en_l_q;
  assign wr_en_r   = wr_en_r_q;
  assign wr_addr   = {wr_bank_q, wr_ptr_q};
  assign blk_ready = blk_ready_q;
  assign blk_bank  = blk_bank_q;
  assign tx_addr   = {tx_bank_q, wr_ptr_q};
  assign tx_mute   = tx_mute_q;
  assign overrun   = overrun_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_block_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_block_sched                                          |
// | Function : Self-checking bench for audio_block_sched: vector table,      |
// |            directed block sequences and random LRCK/handshake traffic    |
// |            against a frame/block-level reference model.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_audio_block_sched;

  logic       clk = 1'b0;
  logic       rst, lrck, proc_done, clr_flags;
  logic       wr_en_l, wr_en_r, blk_ready, blk_bank, tx_mute, overrun, underrun;
  logic [6:0] wr_addr, tx_addr;
`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0] blk_count;
  logic [7:0]  ovr_count;
`endif

  audio_block_sched #(.PTR_BITS(6)) dut (
    .clk(clk), .rst(rst), .lrck(lrck), .proc_done(proc_done), .clr_flags(clr_flags),
`ifdef AUDIO_SCHED_STATS_EN
    .blk_count(blk_count), .ovr_count(ovr_count),
`endif
    .wr_en_l(wr_en_l), .wr_en_r(wr_en_r), .wr_addr(wr_addr), .blk_ready(blk_ready),
    .blk_bank(blk_bank), .tx_addr(tx_addr), .tx_mute(tx_mute),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: frames counted as a plain integer, blocks derived by division
  bit m_last, m_armed, m_l, m_r, m_rdy, m_off_bank, m_done, m_done_bank;
  bit m_tx_bank, m_mute, m_ovr, m_und, m_ever;
  int m_frames;

  // Observation helpers
  int         cnt_l, cnt_r;
  logic [6:0] last_r_addr, rise_addr;
  logic       rise_bank, prev_ready;
  bit         lr_lvl;
  int         ph_cnt;

  typedef struct {
    logic        r, l, d, c;
    logic [10:0] exp;   // {wr_en_l, wr_en_r, wr_addr, blk_ready, tx_mute}
  } vec_t;
  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic l, input logic d, input logic c);
    bit incr;
    int blk;
    if (r) begin
      m_last = l; m_armed = 0; m_l = 0; m_r = 0; m_frames = 0;
      m_rdy = 0; m_off_bank = 0; m_done = 0; m_done_bank = 0;
      m_tx_bank = 0; m_mute = 1; m_ovr = 0; m_und = 0; m_ever = 0;
    end else begin
      incr = m_r;
      m_l = m_armed && l && !m_last;
      m_r = m_armed && !l && m_last;
      if (!m_armed && !l && m_last) m_armed = 1;
      m_last = l;
      if (c) begin m_ovr = 0; m_und = 0; end
      if (d && m_rdy) begin
        m_rdy = 0; m_done = 1; m_done_bank = m_off_bank; m_ever = 1;
      end
      if (incr) begin
        m_frames++;
        if (m_frames % 64 == 0) begin
          blk = m_frames / 64 - 1;
          if (m_rdy) m_ovr = 1;
          m_rdy = 1;
          m_off_bank = blk[0];
          if (m_done) begin
            m_tx_bank = m_done_bank; m_done = 0; m_mute = 0;
          end else begin
            m_mute = 1;
            if (m_ever) m_und = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [20:0] model_vec();
    logic [5:0] p;
    logic       b;
    p = 6'(m_frames % 64);
    b = 1'((m_frames / 64) % 2);
    return {m_l, m_r, b, p, m_rdy, m_off_bank, m_tx_bank, p, m_mute, m_ovr, m_und};
  endfunction

  task automatic tick(input logic r, input logic l, input logic d, input logic c);
    logic [20:0] act;
    rst = r; lrck = l; proc_done = d; clr_flags = c;
    @(posedge clk);
    #1;
    model_step(r, l, d, c);
    act = {wr_en_l, wr_en_r, wr_addr, blk_ready, blk_bank, tx_addr, tx_mute, overrun, underrun};
    check("model", 32'(act), 32'(model_vec()));
    if (wr_en_l) cnt_l++;
    if (wr_en_r) begin cnt_r++; last_r_addr = wr_addr; end
    if (blk_ready && !prev_ready) begin rise_bank = blk_bank; rise_addr = wr_addr; end
    prev_ready = blk_ready;
  endtask

  // LRCK generator: toggles every h ticks
  task automatic tick_lr(input int h, input logic r, input logic d, input logic c);
    if (ph_cnt == 0) begin lr_lvl = ~lr_lvl; ph_cnt = h; end
    ph_cnt--;
    tick(r, lr_lvl, d, c);
  endtask

  // One frame: h cycles high then h low; index h+1 of the last frame is the boundary
  task automatic frame(input int h, input int done_idx, input int clr_idx);
    for (int i = 0; i < 2 * h; i++) tick_lr(h, 1'b0, i == done_idx, i == clr_idx);
  endtask

  task automatic block(input int h, input int first, input int done_frame, input int done_idx);
    for (int f = first; f < 64; f++) frame(h, (f == done_frame) ? done_idx : -1, -1);
  endtask

  task automatic set_vec(input int i, input logic r, input logic l, input logic el,
                         input logic er, input logic [6:0] a, input logic rdy, input logic mute);
    vecs[i].r = r; vecs[i].l = l; vecs[i].d = 1'b0; vecs[i].c = 1'b0;
    vecs[i].exp = {el, er, a, rdy, mute};
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lrck = 1'b1; proc_done = 1'b0; clr_flags = 1'b0;
    cnt_l = 0; cnt_r = 0; prev_ready = 1'b0; rise_bank = 1'b0; rise_addr = '0;
    last_r_addr = '0;

    // Reset with lrck high, idle, arming edge, then the first frame
    set_vec(0, 1, 1, 0, 0, 7'd0, 0, 1);
    set_vec(1, 1, 1, 0, 0, 7'd0, 0, 1);
    for (int i = 2; i < 12; i++) set_vec(i, 0, 1, 0, 0, 7'd0, 0, 1);
    set_vec(12, 0, 0, 0, 0, 7'd0, 0, 1);
    set_vec(13, 0, 0, 0, 0, 7'd0, 0, 1);
    set_vec(14, 0, 0, 0, 0, 7'd0, 0, 1);
    set_vec(15, 0, 1, 1, 0, 7'd0, 0, 1);
    set_vec(16, 0, 1, 0, 0, 7'd0, 0, 1);
    set_vec(17, 0, 1, 0, 0, 7'd0, 0, 1);
    set_vec(18, 0, 0, 0, 1, 7'd0, 0, 1);
    set_vec(19, 0, 0, 0, 0, 7'd1, 0, 1);
    set_vec(20, 0, 0, 0, 0, 7'd1, 0, 1);
    for (int i = 0; i < 21; i++) begin
      tick(vecs[i].r, vecs[i].l, vecs[i].d, vecs[i].c);
      check($sformatf("vec%0d", i), 32'({wr_en_l, wr_en_r, wr_addr, blk_ready, tx_mute}),
            32'(vecs[i].exp));
    end
    lr_lvl = 1'b0; ph_cnt = 0;

    // Block 0 with 32-cycle words; done issued 5 cycles after blk_ready
    for (int f = 1; f < 64; f++) frame(32, (f == 63) ? 38 : -1, -1);
    check("b0_cnt_l", 32'(cnt_l), 32'd64);
    check("b0_cnt_r", 32'(cnt_r), 32'd64);
    check("b0_rise_addr", 32'(rise_addr), 32'd64);
    check("b0_rise_bank", 32'(rise_bank), 32'd0);
    check("b0_ready_cleared", 32'(blk_ready), 32'd0);
    check("b0_mute", 32'(tx_mute), 32'd1);
    check("b0_no_underrun", 32'(underrun), 32'd0);

    // Block 1: processed bank 0 becomes the TX bank
    block(4, 0, -1, -1);
    check("b1_mute", 32'(tx_mute), 32'd0);
    check("b1_tx_bank", 32'(tx_addr[6]), 32'd0);
    check("b1_ready", 32'(blk_ready), 32'd1);
    check("b1_bank", 32'(blk_bank), 32'd1);
    check("b1_ovr", 32'(overrun), 32'd0);

    // Block 2: no done -> overrun, underrun, mute
    block(4, 0, -1, -1);
    check("b2_ovr", 32'(overrun), 32'd1);
    check("b2_bank", 32'(blk_bank), 32'd0);
    check("b2_ready", 32'(blk_ready), 32'd1);
    check("b2_mute", 32'(tx_mute), 32'd1);
    check("b2_und", 32'(underrun), 32'd1);

    // Block 3: clear flags, then done coincident with the boundary
    frame(4, -1, 0);
    check("clr_ovr", 32'(overrun), 32'd0);
    check("clr_und", 32'(underrun), 32'd0);
    block(4, 1, 63, 5);
    check("b3_ovr", 32'(overrun), 32'd0);
    check("b3_mute", 32'(tx_mute), 32'd0);
    check("b3_tx_bank", 32'(tx_addr[6]), 32'd0);
    check("b3_ready", 32'(blk_ready), 32'd1);
    check("b3_bank", 32'(blk_bank), 32'd1);

    // Block 4: mid-block done of bank 1
    block(4, 0, 10, 0);
    check("b4_tx_bank", 32'(tx_addr[6]), 32'd1);
    check("b4_mute", 32'(tx_mute), 32'd0);
    check("b4_ovr", 32'(overrun), 32'd0);

    // Block 5: underrun; block 6: recovery
    block(4, 0, -1, -1);
    check("b5_mute", 32'(tx_mute), 32'd1);
    check("b5_und", 32'(underrun), 32'd1);
    block(4, 0, 10, 0);
    check("b6_mute", 32'(tx_mute), 32'd0);
    check("b6_tx_bank", 32'(tx_addr[6]), 32'd1);

    // Reset at wr_ptr = 37, then re-arm
    for (int f = 0; f < 37; f++) frame(4, -1, -1);
    check("pre_rst_addr", 32'(wr_addr), 32'd101);
    tick(1'b1, lr_lvl, 1'b0, 1'b0);
    check("rst_outputs", 32'({wr_en_l, wr_en_r, wr_addr, blk_ready, blk_bank, tx_addr,
                              tx_mute, overrun, underrun}), 32'h0000_0004);
    cnt_l = 0; cnt_r = 0;
    frame(4, -1, -1);
    check("rearm_no_strobe", 32'(cnt_l + cnt_r), 32'd0);
    frame(4, -1, -1);
    check("rearm_r_addr", 32'(last_r_addr), 32'd0);
    check("rearm_addr", 32'(wr_addr), 32'd1);

    // Randomised traffic against the model
    for (int f = 0; f < 600; f++) begin
      int h;
      h = int'($urandom_range(3, 10));
      for (int i = 0; i < 2 * h; i++)
        tick_lr(h, $urandom_range(0, 3999) == 0, $urandom_range(0, 599) == 0,
                $urandom_range(0, 1499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
